// File: rtl/xor_parity_pkg.sv
// Shared types and helpers for the XOR parity serial receiver.
// Holds the receiver FSM state encoding, the parity sense and a
// reduction-XOR helper used by the parity check.
package xor_parity_pkg;

  // Receiver FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Even parity: data bits XOR parity bit must come out 0
  localparam logic EVEN_PARITY = 1'b0;

  // Widest word the reduction helper accepts; narrower words are zero-extended
  localparam int XOR_MAX_W = 16;

  // Reduction XOR over a zero-extended data word
  function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/xor_bit_timer.sv
// Loadable down-counter that paces the serial bit sampling.
// load has priority and sets the count; otherwise the count walks down to
// zero and parks there. tick is high whenever the count sits at zero.
module xor_bit_timer
  import xor_parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int W            = $clog2(CLKS_PER_BIT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Count down from the loaded value, saturating at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, even parity
// bit, stop bit. Each received word is presented on a valid/ready port
// together with per-word parity, framing and overrun flags.
// Build option: define RX_SYNC_EN to pass rx through a 2-flop synchroniser
// (reset value 1) ahead of the FSM; every latency then grows by 2 cycles.
module xor_parity_rx
  import xor_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // First sample lands mid start bit, later ones one full bit apart
  localparam logic [TW-1:0] BIT_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  rx_state_t         state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              perr;
  logic              rx_s;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tick;

`ifdef RX_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  // Timer reload: half a bit on start detect, a full bit after each timed sample
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = BIT_FULL;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          tmr_load = 1'b1;
          tmr_val  = BIT_HALF;
        end
      end
      ST_START, ST_DATA, ST_PARITY: begin
        if (tick) tmr_load = 1'b1;
      end
      default: ;
    endcase
  end

  xor_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .W            (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  // Frame FSM plus output word register; a word load overrides a same-cycle accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid      <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) state <= ST_START;
        end

        ST_START: begin
          if (tick) begin
            idx   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= ST_PARITY;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            perr  <= xor_reduce(XOR_MAX_W'(shreg)) ^ rx_s ^ EVEN_PARITY;
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (tick) begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ~rx_s;
            overrun    <= valid & ~ready;
            valid      <= 1'b1;
            state      <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Self-checking bench for xor_parity_rx (DATA_W=8, CLKS_PER_BIT=4).
// Stimulus pushes the word each frame should deliver into a queue; a
// monitor pops and compares on every valid&ready handshake.
module tb_xor_parity_rx;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    logic          ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          valid, parity_err, frame_err, overrun, busy;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  int   rise_cyc  = 0;
  int   width     = 0;
  logic prev_valid = 1'b0;

  xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: word delivered, parity error if the count of ones in data
  // plus parity bit is odd, framing error if stop bit is 0
  function automatic exp_t model(input logic [DW-1:0] d, input logic p,
                                 input logic s, input logic ov);
    exp_t e;
    e.d  = d;
    e.pe = ((($countones(d) + int'(p)) % 2) != 0);
    e.fe = ~s;
    e.ov = ov;
    return e;
  endfunction

  // Caller enters at posedge+1; leaves at posedge+1 after the stop bit
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    logic ov;
    ov = (exp_q.size() > 0) && !ready;
    if (ov) void'(exp_q.pop_back());
    exp_q.push_back(model(d, p, s, ov));
    start_cyc = cyc;
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = p;
    repeat (C) @(posedge clk);
    #1;
    rx = s;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted word against the scoreboard
  always @(negedge clk) begin
    if (valid && !prev_valid) rise_cyc = cyc;
    if (!valid && prev_valid) width = cyc - rise_cyc;
    prev_valid = valid;
    if (valid && ready && !reset) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual=%0h required=none", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", data_out, e.d);
        chk("word_parity_err", parity_err, e.pe);
        chk("word_frame_err", frame_err, e.fe);
        chk("word_overrun", overrun, e.ov);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, vc, n;
    logic [DW-1:0] d;
    logic p, s;

    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    idle(3);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_flags", {parity_err, frame_err, overrun}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle(3);

    // Clean frame, latency and single-cycle valid
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2);
    chk("latency", rise_cyc - start_cyc, 1 + (DW + 2) * C + C / 2 + SYNC);
    chk("valid_width", width, 1);

    // Wrong parity bit
    send_frame(8'h01, 1'b0, 1'b1);
    idle(3);

    // Stop bit 0, line stuck low
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(10);
    chk("stuck_low_busy", busy, 1);
    rx = 1'b1;
    idle(3 + SYNC);
    chk("stuck_low_release_busy", busy, 0);

    // One-clock glitch on an idle line
    rx = 1'b0;
    bc = 0;
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) rx = 1'b1;
      if (busy)  bc++;
      if (valid) vc++;
    end
    chk("glitch_busy_cycles", bc, 2);
    chk("glitch_valid", vc, 0);

    // Overrun with ready held low
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data_out, 8'h22);
    chk("ovr_flag", overrun, 1);
    ready = 1'b1;
    idle(1);
    chk("ovr_cleared_valid", valid, 0);
    chk("ovr_cleared_flag", overrun, 0);
    idle(2);

    // Reset pulsed during data bit 3 of 0xFF
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      idle(C);
    end
    idle(2);
    chk("mid_frame_busy", busy, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_flags", {parity_err, frame_err, overrun}, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(3);

    // Randomised frames
    for (int k = 0; k < 24; k++) begin
      d = DW'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      if (!s) begin
        idle($urandom_range(1, 5));
        rx = 1'b1;
        idle($urandom_range(1, 4));
      end else begin
        idle($urandom_range(0, 3));
      end
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
